// File: rtl/p405s_mmu_pkg.sv
// ---------------------------------------------------------------------------
// p405s_mmu_pkg
// Shared MMU definitions for the ITLB refill path: refill FSM state
// encoding, shadow-word count and word widths, plus a write-select decoder.
// ---------------------------------------------------------------------------
package p405s_mmu_pkg;

    localparam int unsigned NUM_SHADOW = 4;
    localparam int unsigned EPN_W      = 22;
    localparam int unsigned DSIZE_W    = 7;
    localparam int unsigned VICTIM_W   = $clog2(NUM_SHADOW);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_WRITE = 3'd2,
        ST_EXC   = 3'd3,
        ST_INVAL = 3'd4
    } itlb_refill_state_t;

    // Active-low one-hot select; bit 0 is the leftmost (word 0).
    function automatic logic [0:NUM_SHADOW-1] word_sel_dec_n(
        input logic [VICTIM_W-1:0] victim
    );
        logic [0:NUM_SHADOW-1] sel_n;
        sel_n         = '1;
        sel_n[victim] = 1'b0;
        return sel_n;
    endfunction

endpackage

// File: rtl/p405s_itlb_refill_ctl_if.sv
// ---------------------------------------------------------------------------
// p405s_itlb_refill_ctl_if
// Lookup handshake between the ITLB refill controller and the unified TLB.
//   utlbReq/utlbEA           : request and captured lookup address
//   utlbAck                  : lookup complete; result valid only while 1
//   utlbHit/EPN/RPN/DSize/I/E/U0 : lookup result
// master = refill controller, slave = unified TLB.
// ---------------------------------------------------------------------------
interface p405s_itlb_refill_ctl_if;
    import p405s_mmu_pkg::*;

    logic               utlbReq;
    logic [0:EPN_W-1]   utlbEA;
    logic               utlbAck;
    logic               utlbHit;
    logic [0:EPN_W-1]   utlbEPN;
    logic [0:EPN_W-1]   utlbRPN;
    logic [0:DSIZE_W-1] utlbDSize;
    logic               utlbI;
    logic               utlbE;
    logic               utlbU0;

    modport master (
        output utlbReq, utlbEA,
        input  utlbAck, utlbHit, utlbEPN, utlbRPN, utlbDSize,
               utlbI, utlbE, utlbU0
    );

    modport slave (
        input  utlbReq, utlbEA,
        output utlbAck, utlbHit, utlbEPN, utlbRPN, utlbDSize,
               utlbI, utlbE, utlbU0
    );

endinterface

// File: rtl/p405s_itlb_victim_ctr.sv
// ---------------------------------------------------------------------------
// p405s_itlb_victim_ctr
// Round-robin shadow-word victim pointer. Wraps at NUM_SHADOW.
//   clk, rst_n : clock, async active-low reset
//   clr        : force to 0 (priority over inc)
//   inc        : advance by one
//   victim     : current victim index
// ---------------------------------------------------------------------------
module p405s_itlb_victim_ctr
    import p405s_mmu_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clr,
    input  logic                inc,
    output logic [VICTIM_W-1:0] victim
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            victim <= '0;
        end else if (clr) begin
            victim <= '0;
        end else if (inc) begin
            victim <= victim + 1'b1;
        end
    end

endmodule

// File: rtl/p405s_itlb_refill_ctl.sv
// ---------------------------------------------------------------------------
// p405s_itlb_refill_ctl
// ITLB miss refill controller: on a translated-fetch miss it requests a
// lookup from the unified TLB, writes a hit into the next victim shadow word,
// or raises an ITLB-miss exception; isync/tlbia flushes all shadow words.
// Ports:
//   CB, Reset_N           : clock, async active-low reset
//   Miss, VCT_msrIR, isEA : fetch miss, translation enable, fetch page
//   invalAll              : flush-all request
//   utlb                  : unified-TLB lookup handshake (master side)
//   isEPN/RPN/DSize/I/E/U0: registered shadow-word write data
//   WordSel_N             : active-low one-hot shadow-word write select
//   invalidate            : flush pulse to all shadow words
//   itlbMissExc           : one-cycle ITLB-miss exception
//   refillCnt             : saturating refill count, only when
//                           P405S_ITLB_REFILL_CNT_EN is defined
// ---------------------------------------------------------------------------
module p405s_itlb_refill_ctl
    import p405s_mmu_pkg::*;
(
    input  logic                   CB,
    input  logic                   Reset_N,
    input  logic                   Miss,
    input  logic                   VCT_msrIR,
    input  logic [0:EPN_W-1]       isEA,
    input  logic                   invalAll,
    p405s_itlb_refill_ctl_if.master utlb,
    output logic [0:EPN_W-1]       isEPN,
    output logic [0:EPN_W-1]       RPN,
    output logic [0:DSIZE_W-1]     DSize,
    output logic                   I,
    output logic                   E,
    output logic                   U0,
    output logic [0:NUM_SHADOW-1]  WordSel_N,
    output logic                   invalidate,
`ifdef P405S_ITLB_REFILL_CNT_EN
    output logic [0:15]            refillCnt,
`endif
    output logic                   itlbMissExc
);

    itlb_refill_state_t state_q, state_d;

    logic [VICTIM_W-1:0] victim;
    logic                victim_inc;
    logic                victim_clr;
    logic                ea_load;
    logic                data_load;

    logic [0:EPN_W-1]    ea_q;
    logic [0:EPN_W-1]    epn_q;
    logic [0:EPN_W-1]    rpn_q;
    logic [0:DSIZE_W-1]  dsize_q;
    logic                i_q;
    logic                e_q;
    logic                u0_q;

    always_ff @(posedge CB or negedge Reset_N) begin
        if (!Reset_N) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // invalAll wins over Miss in IDLE and aborts an outstanding lookup in
    // REQ (a coincident ack is dropped); WRITE/EXC finish their single
    // cycle of output before diverting to INVAL.
    always_comb begin
        state_d     = state_q;
        ea_load     = 1'b0;
        data_load   = 1'b0;
        victim_inc  = 1'b0;
        victim_clr  = 1'b0;
        WordSel_N   = '1;
        invalidate  = 1'b0;
        itlbMissExc = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (invalAll) begin
                    state_d = ST_INVAL;
                end else if (Miss && VCT_msrIR) begin
                    ea_load = 1'b1;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (invalAll) begin
                    state_d = ST_INVAL;
                end else if (utlb.utlbAck) begin
                    if (utlb.utlbHit) begin
                        data_load = 1'b1;
                        state_d   = ST_WRITE;
                    end else begin
                        state_d   = ST_EXC;
                    end
                end
            end
            ST_WRITE: begin
                WordSel_N  = word_sel_dec_n(victim);
                victim_inc = 1'b1;
                state_d    = invalAll ? ST_INVAL : ST_IDLE;
            end
            ST_EXC: begin
                itlbMissExc = 1'b1;
                state_d     = invalAll ? ST_INVAL : ST_IDLE;
            end
            ST_INVAL: begin
                invalidate = 1'b1;
                victim_clr = 1'b1;
                state_d    = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign utlb.utlbReq = (state_q == ST_REQ);
    assign utlb.utlbEA  = ea_q;

    always_ff @(posedge CB or negedge Reset_N) begin
        if (!Reset_N) begin
            ea_q <= '0;
        end else if (ea_load) begin
            ea_q <= isEA;
        end
    end

    always_ff @(posedge CB or negedge Reset_N) begin
        if (!Reset_N) begin
            epn_q   <= '0;
            rpn_q   <= '0;
            dsize_q <= '0;
            i_q     <= 1'b0;
            e_q     <= 1'b0;
            u0_q    <= 1'b0;
        end else if (data_load) begin
            epn_q   <= utlb.utlbEPN;
            rpn_q   <= utlb.utlbRPN;
            dsize_q <= utlb.utlbDSize;
            i_q     <= utlb.utlbI;
            e_q     <= utlb.utlbE;
            u0_q    <= utlb.utlbU0;
        end
    end

    assign isEPN = epn_q;
    assign RPN   = rpn_q;
    assign DSize = dsize_q;
    assign I     = i_q;
    assign E     = e_q;
    assign U0    = u0_q;

    p405s_itlb_victim_ctr u_victim_ctr (
        .clk    (CB),
        .rst_n  (Reset_N),
        .clr    (victim_clr),
        .inc    (victim_inc),
        .victim (victim)
    );

`ifdef P405S_ITLB_REFILL_CNT_EN
    logic [0:15] refill_cnt_q;

    always_ff @(posedge CB or negedge Reset_N) begin
        if (!Reset_N) begin
            refill_cnt_q <= '0;
        end else if (state_q == ST_INVAL) begin
            refill_cnt_q <= '0;
        end else if ((state_q == ST_WRITE) && (refill_cnt_q != '1)) begin
            refill_cnt_q <= refill_cnt_q + 16'd1;
        end
    end

    assign refillCnt = refill_cnt_q;
`endif

endmodule

// File: tb/tb_p405s_itlb_refill_ctl.sv
module tb_p405s_itlb_refill_ctl;
    import p405s_mmu_pkg::*;

    logic               CB;
    logic               Reset_N;
    logic               Miss;
    logic               VCT_msrIR;
    logic [0:21]        isEA;
    logic               invalAll;
    logic [0:21]        isEPN;
    logic [0:21]        RPN;
    logic [0:6]         DSize;
    logic               I;
    logic               E;
    logic               U0;
    logic [0:3]         WordSel_N;
    logic               invalidate;
    logic               itlbMissExc;
`ifdef P405S_ITLB_REFILL_CNT_EN
    logic [0:15]        refillCnt;
`endif

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    p405s_itlb_refill_ctl_if utlb_if ();

    p405s_itlb_refill_ctl dut (
        .CB          (CB),
        .Reset_N     (Reset_N),
        .Miss        (Miss),
        .VCT_msrIR   (VCT_msrIR),
        .isEA        (isEA),
        .invalAll    (invalAll),
        .utlb        (utlb_if.master),
        .isEPN       (isEPN),
        .RPN         (RPN),
        .DSize       (DSize),
        .I           (I),
        .E           (E),
        .U0          (U0),
        .WordSel_N   (WordSel_N),
        .invalidate  (invalidate),
`ifdef P405S_ITLB_REFILL_CNT_EN
        .refillCnt   (refillCnt),
`endif
        .itlbMissExc (itlbMissExc)
    );

    initial CB = 1'b0;
    always #5 CB = ~CB;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance past the next rising edge; outputs are sampled 1 unit later.
    task automatic step();
        @(posedge CB);
        #1;
    endtask

    task automatic set_ack(input logic ack, input logic hit, input logic [0:21] rpn);
        utlb_if.utlbAck   = ack;
        utlb_if.utlbHit   = hit;
        utlb_if.utlbRPN   = rpn;
        utlb_if.utlbEPN   = 22'h00F0F;
        utlb_if.utlbDSize = 7'h05;
        utlb_if.utlbI     = 1'b1;
        utlb_if.utlbE     = 1'b0;
        utlb_if.utlbU0    = 1'b1;
    endtask

    // Miss -> REQ -> immediate ack; checks the resulting one-cycle outcome.
    task automatic refill(input string tag, input logic hit, input logic [0:21] rpn,
                          input logic [3:0] exp_ws, input logic [0:21] exp_rpn);
        Miss = 1'b1;
        isEA = rpn ^ 22'h2AAAA;
        step();
        Miss = 1'b0;
        chk({tag, "_req"}, utlb_if.utlbReq, 1);
        chk({tag, "_ea"}, utlb_if.utlbEA, rpn ^ 22'h2AAAA);
        set_ack(1'b1, hit, rpn);
        step();
        set_ack(1'b0, 1'b0, '0);
        chk({tag, "_ws"}, WordSel_N, exp_ws);
        chk({tag, "_exc"}, itlbMissExc, !hit);
        chk({tag, "_rpn"}, RPN, exp_rpn);
        step();
        chk({tag, "_idle_ws"}, WordSel_N, 4'b1111);
        chk({tag, "_idle_exc"}, itlbMissExc, 0);
    endtask

    initial begin
        Reset_N   = 1'b0;
        Miss      = 1'b0;
        VCT_msrIR = 1'b1;
        isEA      = '0;
        invalAll  = 1'b0;
        set_ack(1'b0, 1'b0, '0);
        step();
        step();

        chk("rst_req", utlb_if.utlbReq, 0);
        chk("rst_ws", WordSel_N, 4'b1111);
        chk("rst_inval", invalidate, 0);
        chk("rst_exc", itlbMissExc, 0);
        chk("rst_rpn", RPN, 0);
        chk("rst_ea", utlb_if.utlbEA, 0);
        Reset_N = 1'b1;
        step();

        // Basic refill with two-cycle ack latency
        Miss = 1'b1;
        isEA = 22'h0ABCD;
        step();
        Miss = 1'b0;
        chk("a_req_c1", utlb_if.utlbReq, 1);
        chk("a_ea_c1", utlb_if.utlbEA, 22'h0ABCD);
        step();
        chk("a_req_c2", utlb_if.utlbReq, 1);
        chk("a_ea_c2", utlb_if.utlbEA, 22'h0ABCD);
        chk("a_ws_c2", WordSel_N, 4'b1111);
        set_ack(1'b1, 1'b1, 22'h12345);
        step();
        set_ack(1'b0, 1'b0, '0);
        chk("a_req_c3", utlb_if.utlbReq, 0);
        chk("a_ws_c3", WordSel_N, 4'b0111);
        chk("a_rpn", RPN, 22'h12345);
        chk("a_epn", isEPN, 22'h00F0F);
        chk("a_dsize", DSize, 7'h05);
        chk("a_iue", {I, E, U0}, 3'b101);
        step();
        chk("a_ws_c4", WordSel_N, 4'b1111);

        // Flush to restart the victim at word 0
        invalAll = 1'b1;
        step();
        invalAll = 1'b0;
        chk("f_inval", invalidate, 1);
        chk("f_ws", WordSel_N, 4'b1111);
        step();
        chk("f_inval_end", invalidate, 0);
        chk("f_rpn_kept", RPN, 22'h12345);

        // Five refills: victim wraps
        refill("w0", 1'b1, 22'h00001, 4'b0111, 22'h00001);
        refill("w1", 1'b1, 22'h00002, 4'b1011, 22'h00002);
        refill("w2", 1'b1, 22'h00003, 4'b1101, 22'h00003);
        refill("w3", 1'b1, 22'h00004, 4'b1110, 22'h00004);
        refill("w4", 1'b1, 22'h00005, 4'b0111, 22'h00005);

        // Lookup miss: exception, no write, victim stays at 1
        refill("m0", 1'b0, 22'h3FFFF, 4'b1111, 22'h00005);
        refill("m1", 1'b1, 22'h00006, 4'b1011, 22'h00006);

        // invalAll in REQ with coincident ack: dropped, flush, victim 0
        Miss = 1'b1;
        step();
        Miss = 1'b0;
        chk("ir_req", utlb_if.utlbReq, 1);
        set_ack(1'b1, 1'b1, 22'h3FFFF);
        invalAll = 1'b1;
        step();
        set_ack(1'b0, 1'b0, '0);
        invalAll = 1'b0;
        chk("ir_req_drop", utlb_if.utlbReq, 0);
        chk("ir_ws", WordSel_N, 4'b1111);
        chk("ir_inval", invalidate, 1);
        chk("ir_rpn", RPN, 22'h00006);
        step();
        chk("ir_inval_end", invalidate, 0);
        refill("ir_next", 1'b1, 22'h00007, 4'b0111, 22'h00007);

        // invalAll during WRITE: write completes, then flush
        Miss = 1'b1;
        step();
        Miss = 1'b0;
        set_ack(1'b1, 1'b1, 22'h00008);
        step();
        set_ack(1'b0, 1'b0, '0);
        chk("iw_ws", WordSel_N, 4'b1011);
        invalAll = 1'b1;
        step();
        invalAll = 1'b0;
        chk("iw_inval", invalidate, 1);
        chk("iw_ws_off", WordSel_N, 4'b1111);
        step();

        // Miss and invalAll together in IDLE
        Miss = 1'b1;
        invalAll = 1'b1;
        step();
        Miss = 1'b0;
        invalAll = 1'b0;
        chk("mi_inval", invalidate, 1);
        chk("mi_req", utlb_if.utlbReq, 0);
        step();
        chk("mi_req2", utlb_if.utlbReq, 0);
        chk("mi_inval_end", invalidate, 0);

        // Translation disabled: Miss ignored
        VCT_msrIR = 1'b0;
        Miss = 1'b1;
        step();
        Miss = 1'b0;
        VCT_msrIR = 1'b1;
        chk("ir0_req", utlb_if.utlbReq, 0);
        step();
        chk("ir0_req2", utlb_if.utlbReq, 0);

        // Reset mid-REQ, then a stale ack
        refill("pre_rst", 1'b1, 22'h00009, 4'b0111, 22'h00009);
        Miss = 1'b1;
        isEA = 22'h15555;
        step();
        Miss = 1'b0;
        chk("rr_req", utlb_if.utlbReq, 1);
        Reset_N = 1'b0;
        #1;
        chk("rr_req_async", utlb_if.utlbReq, 0);
        chk("rr_rpn_async", RPN, 0);
        chk("rr_ea_async", utlb_if.utlbEA, 0);
        #1;
        Reset_N = 1'b1;
        step();
        set_ack(1'b1, 1'b1, 22'h2BCDE);
        step();
        set_ack(1'b0, 1'b0, '0);
        chk("rr_stale_ws", WordSel_N, 4'b1111);
        chk("rr_stale_req", utlb_if.utlbReq, 0);
        chk("rr_stale_rpn", RPN, 0);
        step();
        chk("rr_stale_ws2", WordSel_N, 4'b1111);
        refill("rr_next", 1'b1, 22'h0000A, 4'b0111, 22'h0000A);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
